ni_packet_tx: RTL
=================

# ni_packet_tx

Network-interface packet transmitter on the injection side of a router's local port. Takes a packet request (destination coordinates, VC, length) and a payload stream, and emits a head flit followed by body and tail flits into the router's local input port. The head flit carries the destination X/Y fields that the router's route-computation stage decodes. Flow control is credit-based per VC against the router input buffer depth.

## Interface
- `DATAW`, 32: flit data width.
- `VCH`, 2: number of virtual channels. `VCHW = $clog2(VCH)`.
- `BUF_DEPTH`, 4: router input-buffer depth per VC, which is also the initial credit count.
- `ARRAYW`, 4: coordinate width.
- `LENW`, 4: body-length field width.
- `clk` in 1: clock.
- `rst_` in 1: asynchronous, active-low reset.
- `my_xpos`, `my_ypos` in ARRAYW each: own coordinates, written into the source fields.
- `req_valid` in 1, `req_ready` out 1: packet request handshake.
- `req_dst_x`, `req_dst_y` in ARRAYW each: destination coordinates.
- `req_vch` in VCHW: VC used for the whole packet.
- `req_len` in LENW: number of payload flits after the head; 0 means a single-flit packet.
- `pl_valid` in 1, `pl_ready` out 1, `pl_data` in DATAW: payload stream.
- `flit_valid` out 1: registered; one flit per high cycle.
- `flit_type` out 2: HEAD=0, BODY=1, TAIL=2, HEADTAIL=3.
- `flit_vch` out VCHW: VC of the flit.
- `flit_data` out DATAW: flit payload.
- `credit_in` in VCH: one-hot-per-bit pulse; returns one buffer slot on that VC.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky; set on a credit return that would exceed BUF_DEPTH.

## Operation
- Head flit data layout:
  - `[ARRAYW-1:0]` = dst_x.
  - `[2*ARRAYW-1:ARRAYW]` = dst_y.
  - Next ARRAYW bits = src_x, then ARRAYW bits = src_y.
  - Next LENW bits = len.
  - All remaining bits = 0.
- FSM states:
  - **IDLE**: `req_ready`=1. On `req_valid`, latch dst, vch and len, capture src from `my_xpos`/`my_ypos`, and go to HEAD.
  - **HEAD**: if `credit[vch]>0`, register the head flit. Type is HEADTAIL if len==0, otherwise HEAD. Decrement credit. Go to IDLE if len==0, otherwise go to BODY with `remaining`=len. If no credit, stall in HEAD.
  - **BODY**: `pl_ready = credit[vch]>0`. On `pl_valid && pl_ready`, register a flit with `pl_data`. Type is TAIL if `remaining`==1, otherwise BODY. Decrement credit and `remaining`. After the tail, go to IDLE.
- Credit counters, one per VC:
  - Width `$clog2(BUF_DEPTH+1)`; reset value BUF_DEPTH.
  - A send on a VC decrements its counter; a `credit_in` pulse increments it.
  - A send and a credit on the same VC in the same cycle leave the count unchanged.
  - Credits on other VCs are accepted in any state.
  - A credit arriving at BUF_DEPTH with no send that cycle: count holds and `err` is set until reset.
- Self-addressed requests (dst equals own coordinates) are sent normally. The router delivers them to its local output.
- Full payload stalls are legal. `flit_valid` stays low until data and a credit are both present.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready`=1, `pl_ready`=0.
  - `flit_valid`=0; `flit_type`, `flit_vch`, `flit_data` = 0.
  - `busy`=0, `err`=0.
  - All credits = BUF_DEPTH.
- Latency:
  - Request accepted at edge T0.
  - Head flit registered at T1 (credits available), visible in the cycle after T1.
  - Body flits: registered at the payload-handshake edge, visible the next cycle.
  - Peak rate: one flit per cycle.
- A new request is accepted only in IDLE. Back-to-back packets have one idle-accept cycle between the tail and the next head.
- Reset asserted mid-packet aborts the packet immediately. There is no resumption and credits restore to BUF_DEPTH.
- `flit_*` outputs hold their values when `flit_valid`=0. The receiver must ignore them.

## Structure
- Shared in the project defines header:
  - Flit type encodings.
  - Head-field LSB/MSB constants: DSTX, DSTY, SRCX, SRCY, LEN.
  - The `Enable_` reset polarity.
- Sub-module `ni_credit_counter`: one instance per VC (inputs: dec, inc; outputs: count, nonzero, overflow).
- FSM, flit register and length counter live in the top module.

## Test plan
- Reset, then a request with dst (2,3), len 0 from node (1,1) → one flit, type 3, `data[15:0]`=0x1132, credit[vch] drops to 3.
- Request with len 3 and continuous payload 0xA, 0xB, 0xC on vch 1 → HEAD, BODY 0xA, BODY 0xB, TAIL 0xC on consecutive cycles; `busy` falls after the tail.
- BUF_DEPTH=4, no credit returns, len 6 → exactly 4 flits sent, then stall. Pulse `credit_in[vch]` twice → 2 more flits.
- Simultaneous send and credit on the same VC for 5 cycles → count constant at its pre-value; `err` stays 0.
- Credit pulse with the count already at 4 → `err`=1 and stays 1; count remains 4.
- Assert `rst_` in the middle of the body of a len-5 packet → outputs return to reset values asynchronously. Next request starts with a head flit and full credits.

Source files
------------

// File: rtl/ni_packet_tx_pkg.sv
// Shared definitions for the NI packet transmitter: flit type codes, head-flit
// field positions and the reset assertion level.
// Head-field positions below describe the layout for the default coordinate/length widths.
package ni_packet_tx_pkg;

  // Level of rst_ that holds the logic in reset.
  localparam logic ENABLE_ = 1'b0;

  localparam int NI_ARRAYW = 4;
  localparam int NI_LENW   = 4;

  // Head flit: dst_x | dst_y | src_x | src_y | len, packed from bit 0 upwards.
  localparam int DSTX_LSB = 0;
  localparam int DSTX_MSB = NI_ARRAYW - 1;
  localparam int DSTY_LSB = NI_ARRAYW;
  localparam int DSTY_MSB = 2*NI_ARRAYW - 1;
  localparam int SRCX_LSB = 2*NI_ARRAYW;
  localparam int SRCX_MSB = 3*NI_ARRAYW - 1;
  localparam int SRCY_LSB = 3*NI_ARRAYW;
  localparam int SRCY_MSB = 4*NI_ARRAYW - 1;
  localparam int LEN_LSB  = 4*NI_ARRAYW;
  localparam int LEN_MSB  = 4*NI_ARRAYW + NI_LENW - 1;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC credit counter tracking free slots in the router input buffer.
// Latency: count updates on the edge after dec/inc; nonzero/overflow are combinational.
// Backpressure: sender must only assert dec while nonzero; excess credits are flagged, not counted.
module ni_credit_counter
  import ni_packet_tx_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          nonzero,
  output logic          overflow
);

  localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

  assign nonzero  = (count != '0);
  // A credit with nothing outstanding can only come from a confused receiver.
  assign overflow = inc && !dec && (count == FULL);

  // Send and credit in the same cycle cancel; a credit at full holds the count.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ENABLE_) begin
      count <= FULL;
    end else if (inc && !dec && (count != FULL)) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/ni_packet_tx.sv
// NI injection-side packet transmitter: request + payload stream -> head/body/tail flits.
// Latency: head flit registered one edge after request accept; body flit on its payload-handshake edge.
// Backpressure: per-VC credits gate every flit; without a credit the head stalls and pl_ready drops.
module ni_packet_tx
  import ni_packet_tx_pkg::*;
#(
  parameter int DATAW     = 32,
  parameter int VCH       = 2,
  parameter int BUF_DEPTH = 4,
  parameter int ARRAYW    = NI_ARRAYW,
  parameter int LENW      = NI_LENW,
  localparam int VCHW     = $clog2(VCH)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ARRAYW-1:0] my_xpos,
  input  logic [ARRAYW-1:0] my_ypos,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ARRAYW-1:0] req_dst_x,
  input  logic [ARRAYW-1:0] req_dst_y,
  input  logic [VCHW-1:0]   req_vch,
  input  logic [LENW-1:0]   req_len,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATAW-1:0]  pl_data,
  output logic              flit_valid,
  output logic [1:0]        flit_type,
  output logic [VCHW-1:0]   flit_vch,
  output logic [DATAW-1:0]  flit_data,
  input  logic [VCH-1:0]    credit_in,
  output logic              busy,
  output logic              err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  tx_state_e             state_q, state_d;
  logic [ARRAYW-1:0]     dst_x_q, dst_y_q, src_x_q, src_y_q;
  logic [VCHW-1:0]       vch_q;
  logic [LENW-1:0]       len_q, rem_q;
  logic [DATAW-1:0]      head_w;
  logic [DATAW-1:0]      flit_data_d;
  flit_type_e            flit_type_d;
  logic                  send;
  logic                  credit_ok;
  logic [VCH-1:0]        cred_dec, cred_nz, cred_ovf;
  logic [VCH-1:0][CW-1:0] cred_cnt;
  logic                  unused_cred_cnt;

  for (genvar i = 0; i < VCH; i++) begin : g_cred
    ni_credit_counter #(.BUF_DEPTH(BUF_DEPTH), .CW(CW)) u_cc (
      .clk      (clk),
      .rst_     (rst_),
      .dec      (cred_dec[i]),
      .inc      (credit_in[i]),
      .count    (cred_cnt[i]),
      .nonzero  (cred_nz[i]),
      .overflow (cred_ovf[i])
    );
  end

  // Raw counts are kept on the instance ports for debug visibility only.
  assign unused_cred_cnt = ^cred_cnt;

  assign credit_ok = cred_nz[vch_q];
  assign busy      = (state_q != S_IDLE);

  // Assemble the head word from the latched request; unused upper bits stay zero.
  always_comb begin
    head_w = '0;
    head_w[DSTX_MSB:DSTX_LSB] = dst_x_q;
    head_w[DSTY_MSB:DSTY_LSB] = dst_y_q;
    head_w[SRCX_MSB:SRCX_LSB] = src_x_q;
    head_w[SRCY_MSB:SRCY_LSB] = src_y_q;
    head_w[LEN_MSB:LEN_LSB]   = len_q;
  end

  // Next state, handshakes and the flit to register this cycle.
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    pl_ready    = 1'b0;
    send        = 1'b0;
    cred_dec    = '0;
    flit_type_d = FLIT_HEAD;
    flit_data_d = head_w;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_HEAD;
      end
      S_HEAD: begin
        flit_type_d = (len_q == '0) ? FLIT_HEADTAIL : FLIT_HEAD;
        if (credit_ok) begin
          send    = 1'b1;
          state_d = (len_q == '0) ? S_IDLE : S_BODY;
        end
      end
      S_BODY: begin
        pl_ready    = credit_ok;
        flit_data_d = pl_data;
        flit_type_d = (rem_q == LENW'(1)) ? FLIT_TAIL : FLIT_BODY;
        if (pl_valid && credit_ok) begin
          send = 1'b1;
          if (rem_q == LENW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (send) cred_dec[vch_q] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ENABLE_) state_q <= S_IDLE;
    else                 state_q <= state_d;
  end

  // Latch the request in IDLE and count down payload flits while in BODY.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ENABLE_) begin
      dst_x_q <= '0;
      dst_y_q <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      vch_q   <= '0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        dst_x_q <= req_dst_x;
        dst_y_q <= req_dst_y;
        src_x_q <= my_xpos;
        src_y_q <= my_ypos;
        vch_q   <= req_vch;
        len_q   <= req_len;
      end
      if (send && state_q == S_HEAD)      rem_q <= len_q;
      else if (send && state_q == S_BODY) rem_q <= rem_q - 1'b1;
    end
  end

  // Flit output register; payload fields hold while no flit is sent.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ENABLE_) begin
      flit_valid <= 1'b0;
      flit_type  <= '0;
      flit_vch   <= '0;
      flit_data  <= '0;
    end else begin
      flit_valid <= send;
      if (send) begin
        flit_type <= flit_type_d;
        flit_vch  <= vch_q;
        flit_data <= flit_data_d;
      end
    end
  end

  // Sticky error on any credit return beyond the buffer depth.
  always_ff @(posedge clk or negedge rst_) begin
    if (rst_ == ENABLE_) err <= 1'b0;
    else if (|cred_ovf)  err <= 1'b1;
  end

endmodule
